// File: rtl/mem_resp_tracker.sv
// rtl/mem_resp_tracker.sv - in-order memory response tracker between EXE and WB
// Optional feature: MEM_TRK_PERF_EN enables the head-load wait-cycle counter.
module mem_resp_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_allowin,
  input  logic             in_is_ld,
  input  logic             in_is_st,
  input  logic [2:0]       in_ld_type,
  input  logic             in_gr_we,
  input  logic [4:0]       in_dest,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  output logic             out_valid,
  input  logic             out_allowin,
  output logic             out_gr_we,
  output logic [4:0]       out_dest,
  output logic [31:0]      out_result,
  output logic [31:0]      out_pc,
  input  logic [4:0]       q_rj,
  input  logic [4:0]       q_rk,
  output logic             q_rj_hit,
  output logic             q_rk_hit,
  output logic             q_rj_stall,
  output logic             q_rk_stall,
  output logic [31:0]      q_rj_data,
  output logic [31:0]      q_rk_data,
  output logic [CNT_W-1:0] occupancy,
  output logic [31:0]      perf_ld_wait
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] vld_q, wait_q, isld_q, we_q;
  logic [2:0]       type_q [DEPTH];
  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      res_q  [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, rsp_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d, drop_q, drop_d, nwait;
  logic [CNT_W:0]   drop_sum;
  logic             full, enq, deq, rsp_found, rsp_apply;

  function automatic logic [31:0] ld_ext(input logic [2:0] t, input logic [1:0] a,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (t)
      3'd1:    ld_ext = {{24{b[7]}}, b};
      3'd2:    ld_ext = {24'd0, b};
      3'd3:    ld_ext = {{16{h[15]}}, h};
      3'd4:    ld_ext = {16'd0, h};
      default: ld_ext = d;
    endcase
  endfunction

  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign out_valid  = vld_q[head_q] && !wait_q[head_q];
  assign deq        = out_valid && out_allowin && !flush;
  assign in_allowin = !flush && (!full || (out_valid && out_allowin));
  assign enq        = in_valid && in_allowin;
  assign occupancy  = cnt_q;

  assign out_gr_we  = out_valid && we_q[head_q];
  assign out_dest   = out_valid ? dest_q[head_q] : 5'd0;
  assign out_result = out_valid ? res_q[head_q]  : 32'd0;
  assign out_pc     = out_valid ? pc_q[head_q]   : 32'd0;

  // Entries are contiguous from head, so the first WAIT seen scanning from head is the oldest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    rsp_found = 1'b0;
    rsp_idx   = '0;
    nwait     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && wait_q[idx]) begin
        nwait = nwait + CNT_W'(1);
        if (!rsp_found) begin
          rsp_found = 1'b1;
          rsp_idx   = idx;
        end
      end
    end
  end

  assign rsp_apply = data_ok && !flush && (drop_q == '0) && rsp_found;

  // Later (younger) matches override earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    q_rj_hit   = 1'b0;
    q_rj_stall = 1'b0;
    q_rj_data  = 32'd0;
    q_rk_hit   = 1'b0;
    q_rk_stall = 1'b0;
    q_rk_data  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && we_q[idx] && q_rj != 5'd0 && dest_q[idx] == q_rj) begin
        q_rj_hit   = 1'b1;
        q_rj_stall = wait_q[idx] && isld_q[idx];
        q_rj_data  = wait_q[idx] ? 32'd0 : res_q[idx];
      end
      if (vld_q[idx] && we_q[idx] && q_rk != 5'd0 && dest_q[idx] == q_rk) begin
        q_rk_hit   = 1'b1;
        q_rk_stall = wait_q[idx] && isld_q[idx];
        q_rk_data  = wait_q[idx] ? 32'd0 : res_q[idx];
      end
    end
  end

  always_comb begin
    head_d   = flush ? '0 : head_q + PTR_W'(deq);
    tail_d   = flush ? '0 : tail_q + PTR_W'(enq);
    cnt_d    = flush ? '0 : cnt_q + CNT_W'(enq) - CNT_W'(deq);
    drop_sum = {1'b0, drop_q} + {1'b0, nwait};
    drop_d   = drop_q;
    // Responses still owed to killed requests must be swallowed before any new entry completes.
    if (flush) begin
      if (data_ok) drop_sum = (drop_sum == '0) ? '0 : drop_sum - 1'b1;
      drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end else if (data_ok && drop_q != '0) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q  <= '0;
      wait_q <= '0;
      isld_q <= '0;
      we_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= 3'd0;
        dest_q[i] <= 5'd0;
        res_q[i]  <= 32'd0;
        pc_q[i]   <= 32'd0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      // A waiting load holds its effective address in res_q until the data arrives.
      if (rsp_apply) begin
        wait_q[rsp_idx] <= 1'b0;
        if (isld_q[rsp_idx])
          res_q[rsp_idx] <= ld_ext(type_q[rsp_idx], res_q[rsp_idx][1:0], rdata);
      end
      if (deq) vld_q[head_q] <= 1'b0;
      if (enq) begin
        vld_q[tail_q]  <= 1'b1;
        wait_q[tail_q] <= in_is_ld || in_is_st;
        isld_q[tail_q] <= in_is_ld;
        we_q[tail_q]   <= in_gr_we;
        type_q[tail_q] <= in_ld_type;
        dest_q[tail_q] <= in_dest;
        res_q[tail_q]  <= in_alu_result;
        pc_q[tail_q]   <= in_pc;
      end
    end
  end

`ifdef MEM_TRK_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      perf_q <= 32'd0;
    else if (vld_q[head_q] && wait_q[head_q] && isld_q[head_q])
      perf_q <= perf_q + 32'd1;
  end
  assign perf_ld_wait = perf_q;
`else
  assign perf_ld_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_resp_tracker.sv
// tb/tb_mem_resp_tracker.sv - directed scoreboard bench for mem_resp_tracker
module tb_mem_resp_tracker;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic resetn, flush, in_valid, in_allowin, in_is_ld, in_is_st, in_gr_we;
  logic [2:0] in_ld_type;
  logic [4:0] in_dest, out_dest, q_rj, q_rk;
  logic [31:0] in_alu_result, in_pc, rdata, out_result, out_pc, q_rj_data, q_rk_data, perf_ld_wait;
  logic data_ok, out_valid, out_allowin, out_gr_we;
  logic q_rj_hit, q_rk_hit, q_rj_stall, q_rk_stall;
  logic [CNT_W-1:0] occupancy;

  always #5 clk = ~clk;

  mem_resp_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_is_ld(in_is_ld), .in_is_st(in_is_st),
    .in_ld_type(in_ld_type), .in_gr_we(in_gr_we), .in_dest(in_dest),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_gr_we(out_gr_we),
    .out_dest(out_dest), .out_result(out_result), .out_pc(out_pc),
    .q_rj(q_rj), .q_rk(q_rk), .q_rj_hit(q_rj_hit), .q_rk_hit(q_rk_hit),
    .q_rj_stall(q_rj_stall), .q_rk_stall(q_rk_stall), .q_rj_data(q_rj_data),
    .q_rk_data(q_rk_data), .occupancy(occupancy), .perf_ld_wait(perf_ld_wait)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        we;
  } exp_t;

  exp_t sbq[$];
  exp_t pend, got;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic ld, input logic st, input logic [2:0] t, input logic we,
                          input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc,
                          input logic [31:0] exp);
    in_valid = 1'b1; in_is_ld = ld; in_is_st = st; in_ld_type = t; in_gr_we = we;
    in_dest = d; in_alu_result = alu; in_pc = pc;
    pend.res = exp; pend.pc = pc; pend.dest = d; pend.we = we;
  endtask

  // One clock: retire check, scoreboard push, edge, then one-shot inputs return to idle.
  task automatic cyc();
    #1;
    if (flush) sbq.delete();
    else if (out_valid && out_allowin) begin
      if (sbq.size() == 0) chk("retire_unexpected", 32'(out_valid), 32'd0);
      else begin
        got = sbq.pop_front();
        chk("ret_result", out_result, got.res);
        chk("ret_pc", out_pc, got.pc);
        chk("ret_dest", 32'(out_dest), 32'(got.dest));
        chk("ret_we", 32'(out_gr_we), 32'(got.we));
      end
    end
    if (in_valid && !flush) sbq.push_back(pend);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; data_ok = 1'b0; flush = 1'b0; rdata = 32'd0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0]  lt [5];
    logic [31:0] la [5];
    logic [31:0] lr [5];
    logic [31:0] le [5];
    logic [4:0]  dt [4];
    lt = '{3'd4, 3'd3, 3'd2, 3'd0, 3'd1};
    la = '{32'h1002, 32'h1000, 32'h1001, 32'h1004, 32'h1002};
    lr = '{32'hBEEF0000, 32'h12348001, 32'h00009A00, 32'hA5A55A5A, 32'h007F0000};
    le = '{32'h0000BEEF, 32'hFFFF8001, 32'h0000009A, 32'hA5A55A5A, 32'h0000007F};
    dt = '{5'd7, 5'd7, 5'd0, 5'd9};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_is_ld = 1'b0; in_is_st = 1'b0;
    in_ld_type = 3'd0; in_gr_we = 1'b0; in_dest = 5'd0; in_alu_result = 32'd0; in_pc = 32'd0;
    data_ok = 1'b0; rdata = 32'd0; out_allowin = 1'b1; q_rj = 5'd0; q_rk = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_q_rj_hit", 32'(q_rj_hit), 32'd0);
    chk("rst_perf", perf_ld_wait, 32'd0);
    chk("rst_allowin", 32'(in_allowin), 32'd1);
    resetn = 1'b1;

    // ALU entry, then WB backpressure for 5 cycles
    out_allowin = 1'b0; q_rj = 5'd4; q_rk = 5'd5;
    drive_in(1'b0, 1'b0, 3'd0, 1'b1, 5'd4, 32'h12, 32'h1c000000, 32'h12);
    cyc();
    chk("alu_out_valid", 32'(out_valid), 32'd1);
    chk("alu_out_result", out_result, 32'h12);
    chk("alu_out_pc", out_pc, 32'h1c000000);
    chk("alu_rj_hit", 32'(q_rj_hit), 32'd1);
    chk("alu_rj_stall", 32'(q_rj_stall), 32'd0);
    chk("alu_rj_data", q_rj_data, 32'h12);
    chk("alu_rk_hit", 32'(q_rk_hit), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, 32'h12);
    end
    out_allowin = 1'b1;
    cyc();
    chk("alu_drained", 32'(occupancy), 32'd0);

    // ld.b with a same-cycle data_ok that must not apply to it
    q_rj = 5'd5;
    drive_in(1'b1, 1'b0, 3'd1, 1'b1, 5'd5, 32'h1003, 32'h1c000004, 32'hFFFFFF80);
    data_ok = 1'b1; rdata = 32'h80;
    cyc();
    chk("ldb_stall", 32'(q_rj_stall), 32'd1);
    chk("ldb_hit", 32'(q_rj_hit), 32'd1);
    chk("ldb_not_done", 32'(out_valid), 32'd0);
    cyc(); cyc();
    chk("ldb_stall_wait", 32'(q_rj_stall), 32'd1);
    data_ok = 1'b1; rdata = 32'h80000000;
    cyc();
    chk("ldb_stall_clear", 32'(q_rj_stall), 32'd0);
    chk("ldb_fwd", q_rj_data, 32'hFFFFFF80);
    chk("ldb_out_result", out_result, 32'hFFFFFF80);
    cyc();

    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 1'b0, lt[i], 1'b1, 5'd6, la[i], 32'h1c000100 + 32'(4 * i), le[i]);
      cyc();
      data_ok = 1'b1; rdata = lr[i];
      cyc();
      chk("ld_done", 32'(out_valid), 32'd1);
      cyc();
    end
    drive_in(1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h2000, 32'h1c000200, 32'h2000);
    cyc();
    chk("st_wait", 32'(out_valid), 32'd0);
    data_ok = 1'b1;
    cyc();
    chk("st_done", 32'(out_valid), 32'd1);
    cyc();
    chk("ld_sb_empty", sbq.size(), 32'd0);

    // Fill with loads, then four back-to-back responses
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 1'b0, 3'd0, 1'b1, 5'(8 + i), 32'h3000 + 32'(4 * i),
               32'h1c000300 + 32'(4 * i), 32'h11110000 + 32'(i));
      cyc();
    end
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_allowin", 32'(in_allowin), 32'd0);
    for (int i = 0; i < 4; i++) begin
      data_ok = 1'b1; rdata = 32'h11110000 + 32'(i);
      cyc();
    end
    cyc();
    chk("full_drained", 32'(occupancy), 32'd0);
    chk("full_sb_empty", sbq.size(), 32'd0);

    // Full of DONE ALU entries: hazard priority and enqueue+dequeue when full
    out_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b0, 1'b0, 3'd0, 1'b1, dt[i], 32'(i + 1), 32'h1c000400 + 32'(4 * i), 32'(i + 1));
      cyc();
    end
    chk("alu_full_occ", 32'(occupancy), 32'd4);
    chk("alu_full_allowin", 32'(in_allowin), 32'd0);
    q_rj = 5'd7; q_rk = 5'd0;
    #1;
    chk("youngest_hit", 32'(q_rj_hit), 32'd1);
    chk("youngest_data", q_rj_data, 32'd2);
    chk("dest0_nohit", 32'(q_rk_hit), 32'd0);
    out_allowin = 1'b1;
    #1;
    chk("full_bypass_allowin", 32'(in_allowin), 32'd1);
    drive_in(1'b0, 1'b0, 3'd0, 1'b1, 5'd10, 32'd5, 32'h1c000410, 32'd5);
    cyc();
    chk("full_swap_occ", 32'(occupancy), 32'd4);
    repeat (4) cyc();
    chk("alu_full_drained", 32'(occupancy), 32'd0);
    chk("alu_sb_empty", sbq.size(), 32'd0);

    // Flush with two WAIT loads pending and a same-cycle response
    drive_in(1'b1, 1'b0, 3'd0, 1'b1, 5'd11, 32'h4000, 32'h1c000500, 32'd0); cyc();
    drive_in(1'b1, 1'b0, 3'd0, 1'b1, 5'd11, 32'h4004, 32'h1c000504, 32'd0); cyc();
    drive_in(1'b0, 1'b0, 3'd0, 1'b1, 5'd11, 32'h99, 32'h1c000508, 32'h99); cyc();
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    drive_in(1'b0, 1'b0, 3'd0, 1'b1, 5'd3, 32'h55, 32'h1c00050c, 32'h55);
    flush = 1'b1; data_ok = 1'b1; rdata = 32'hBAD;
    #1;
    chk("flush_allowin", 32'(in_allowin), 32'd0);
    cyc();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    q_rj = 5'd12;
    drive_in(1'b1, 1'b0, 3'd0, 1'b1, 5'd12, 32'h5000, 32'h1c000600, 32'hCAFE0000);
    cyc();
    data_ok = 1'b1; rdata = 32'hDEAD0000;
    cyc();
    chk("drop_discard_stall", 32'(q_rj_stall), 32'd1);
    chk("drop_discard_valid", 32'(out_valid), 32'd0);
    data_ok = 1'b1; rdata = 32'hCAFE0000;
    cyc();
    chk("post_drop_valid", 32'(out_valid), 32'd1);
    chk("post_drop_result", out_result, 32'hCAFE0000);
    cyc();
    chk("flush_sb_empty", sbq.size(), 32'd0);

    // Asynchronous reset mid-operation
    drive_in(1'b0, 1'b0, 3'd0, 1'b1, 5'd2, 32'h77, 32'h1c000700, 32'h77);
    out_allowin = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    sbq.delete();
    @(negedge clk);
    resetn = 1'b1;
    out_allowin = 1'b1;
    #1;

    // Load waiting at head for 7 cycles
    drive_in(1'b1, 1'b0, 3'd0, 1'b1, 5'd13, 32'h6000, 32'h1c000800, 32'h77);
    cyc();
    repeat (6) cyc();
    data_ok = 1'b1; rdata = 32'h77;
    cyc();
`ifdef MEM_TRK_PERF_EN
    chk("perf_ld_wait", perf_ld_wait, 32'd7);
`else
    chk("perf_ld_wait", perf_ld_wait, 32'd0);
`endif
    cyc();
    chk("final_occ", 32'(occupancy), 32'd0);
    chk("final_sb_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
